// File: rtl/oc_bank_arbiter_pkg.sv
// Shared constants, types and the bank-select helper for the operand-collector register read stage.
package oc_pkg;
  localparam int NUM_BANKS     = 4;
  localparam int BANK_SEL_HI   = 4;
  localparam int BANK_SEL_LO   = 3;
  localparam int REGS_PER_BANK = 8;
  localparam int REG_ID_W      = 5;
  localparam int SLOT_ID_W     = 3;
  localparam int BANK_W        = BANK_SEL_HI - BANK_SEL_LO + 1;

  typedef logic [SLOT_ID_W-1:0] slot_id_t;
  typedef logic [REG_ID_W-1:0]  reg_id_t;
  typedef logic [BANK_W-1:0]    bank_id_t;

  function automatic bank_id_t bank_of(input reg_id_t id);
    return id[BANK_SEL_HI:BANK_SEL_LO];
  endfunction
endpackage

// File: rtl/oc_bank_arbiter_if.sv
// Request, writeback and per-bank return buses between the collector units and the bank arbiter.
interface oc_bank_arbiter_if
  import oc_pkg::*;
#(
  parameter int NS     = 8,
  parameter int DATA_W = 32,
  parameter int OCID_W = 3
);
  logic [NS-1:0]             req_vld;
  logic [NS*REG_ID_W-1:0]    req_reg_id;
  logic [NS-1:0]             req_rdy;
  logic                      wb_en;
  logic [REG_ID_W-1:0]       wb_reg_id;
  logic [DATA_W-1:0]         wb_data;
  logic [NUM_BANKS*DATA_W-1:0] bk_data;
  logic [NUM_BANKS-1:0]      bk_vld;
  logic [NUM_BANKS*OCID_W-1:0] bk_ocid;
  logic [NUM_BANKS-1:0]      bk_bz;

  modport master (
    output req_vld, req_reg_id, wb_en, wb_reg_id, wb_data,
    input  req_rdy, bk_data, bk_vld, bk_ocid, bk_bz
  );

  modport slave (
    input  req_vld, req_reg_id, wb_en, wb_reg_id, wb_data,
    output req_rdy, bk_data, bk_vld, bk_ocid, bk_bz
  );
endinterface

// File: rtl/oc_bank_arbiter_rr_arbiter.sv
// NS-wide round-robin picker; the pointer moves past the winner only when the grant is taken.
module oc_rr_arbiter #(
  parameter int NS    = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NS-1:0]    i_req,
  input  logic             i_en,
  output logic             o_any,
  output logic [IDX_W-1:0] o_idx
);
  logic [IDX_W-1:0] r_ptr;

  always_comb begin
    int j;
    logic [IDX_W-1:0] w_cand;
    j      = 0;
    w_cand = '0;
    o_any  = 1'b0;
    o_idx  = '0;
    for (int i = 0; i < NS; i++) begin
      j = int'(r_ptr) + i;
      if (j >= NS) j = j - NS;
      w_cand = IDX_W'(j);
      if (!o_any && i_req[w_cand]) begin
        o_any = 1'b1;
        o_idx = w_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_en && o_any) begin
      r_ptr <= (o_idx == IDX_W'(NS - 1)) ? '0 : o_idx + 1'b1;
    end
  end
endmodule

// File: rtl/oc_bank_arbiter.sv
// Banked register file read stage with per-bank round-robin grant and writeback priority.
// Define OC_WB_FORWARD_EN to let a winner reading exactly the written register proceed with wb_data.
module oc_bank_arbiter
  import oc_pkg::*;
#(
  parameter int NUM_OC = 4,
  parameter int DATA_W = 32,
  parameter int OCID_W = 3
) (
  input logic clk,
  input logic rst,
  oc_bank_arbiter_if.slave bus
);
  localparam int NS = 2 * NUM_OC;

  logic [DATA_W-1:0] r_regs [NUM_BANKS*REGS_PER_BANK];
  logic [NS-1:0]     r_pending;
  reg_id_t           r_reg_id [NS];

  logic                  r_bk_vld  [NUM_BANKS];
  logic                  r_bk_bz   [NUM_BANKS];
  logic [OCID_W-1:0]     r_bk_ocid [NUM_BANKS];
  logic [DATA_W-1:0]     r_bk_data [NUM_BANKS];

  logic [NUM_BANKS-1:0]  w_grant;
  logic [OCID_W-1:0]     w_gnt_idx [NUM_BANKS];
  logic [NS-1:0]         w_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANKS*REGS_PER_BANK; i++) r_regs[i] <= '0;
    end else if (bus.wb_en) begin
      r_regs[bus.wb_reg_id] <= bus.wb_data;
    end
  end

  always_comb begin
    w_clr = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      if (w_grant[b]) w_clr[w_gnt_idx[b]] = 1'b1;
  end

  // A slot is never set and cleared together: set needs ~pending, clear needs pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      for (int s = 0; s < NS; s++) r_reg_id[s] <= '0;
    end else begin
      for (int s = 0; s < NS; s++) begin
        if (w_clr[s]) begin
          r_pending[s] <= 1'b0;
        end else if (bus.req_vld[s] && !r_pending[s]) begin
          r_pending[s] <= 1'b1;
          r_reg_id[s]  <= bus.req_reg_id[s*REG_ID_W +: REG_ID_W];
        end
      end
    end
  end

  assign bus.req_rdy = ~r_pending;

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic [NS-1:0]     w_elig;
    logic              w_any;
    logic [OCID_W-1:0] w_idx;
    logic              w_hit;
    logic              w_fwd;
    logic              w_block;

    for (genvar gj = 0; gj < NS; gj++) begin : g_elig
      assign w_elig[gj] = r_pending[gj] && (bank_of(r_reg_id[gj]) == bank_id_t'(gi));
    end

    assign w_hit = bus.wb_en && (bank_of(bus.wb_reg_id) == bank_id_t'(gi));
`ifdef OC_WB_FORWARD_EN
    assign w_fwd = w_hit && w_any && (r_reg_id[w_idx] == bus.wb_reg_id);
`else
    assign w_fwd = 1'b0;
`endif
    assign w_block       = w_hit && !w_fwd;
    assign w_grant[gi]   = w_any && !w_block;
    assign w_gnt_idx[gi] = w_idx;

    oc_rr_arbiter #(
      .NS    (NS),
      .IDX_W (OCID_W)
    ) u_rr (
      .clk   (clk),
      .rst   (rst),
      .i_req (w_elig),
      .i_en  (!w_block),
      .o_any (w_any),
      .o_idx (w_idx)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        r_bk_vld[gi]  <= 1'b0;
        r_bk_bz[gi]   <= 1'b0;
        r_bk_ocid[gi] <= '0;
        r_bk_data[gi] <= '0;
      end else begin
        r_bk_vld[gi] <= w_grant[gi];
        r_bk_bz[gi]  <= w_block;
        if (w_grant[gi]) begin
          r_bk_ocid[gi] <= w_idx;
          r_bk_data[gi] <= w_fwd ? bus.wb_data : r_regs[r_reg_id[w_idx]];
        end
      end
    end

    assign bus.bk_vld[gi]                     = r_bk_vld[gi];
    assign bus.bk_bz[gi]                      = r_bk_bz[gi];
    assign bus.bk_ocid[gi*OCID_W +: OCID_W]   = r_bk_ocid[gi];
    assign bus.bk_data[gi*DATA_W +: DATA_W]   = r_bk_data[gi];
  end
endmodule

// File: tb/tb_oc_bank_arbiter.sv
// Directed bench for oc_bank_arbiter: reset, single read, round-robin, parallel banks, writeback, duplicates.
module tb_oc_bank_arbiter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  oc_bank_arbiter_if bus ();

  oc_bank_arbiter u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] ocid(input int b);
    return bus.bk_ocid[b*3 +: 3];
  endfunction

  function automatic logic [31:0] bdata(input int b);
    return bus.bk_data[b*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_vld    = '0;
    bus.req_reg_id = '0;
    bus.wb_en      = 1'b0;
    bus.wb_reg_id  = '0;
    bus.wb_data    = '0;
  endtask

  task automatic set_req(input int s, input logic [4:0] r);
    bus.req_vld[s]           = 1'b1;
    bus.req_reg_id[s*5 +: 5] = r;
  endtask

  task automatic set_wb(input logic [4:0] r, input logic [31:0] d);
    bus.wb_en     = 1'b1;
    bus.wb_reg_id = r;
    bus.wb_data   = d;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    $display("test_reset");
    n_checks++; if (bus.req_rdy !== 8'hFF) begin n_fail++; $display("FAIL reset_rdy got=%h exp=ff", bus.req_rdy); end
    n_checks++; if (bus.bk_vld !== 4'h0) begin n_fail++; $display("FAIL reset_vld got=%h exp=0", bus.bk_vld); end
    n_checks++; if (bus.bk_bz !== 4'h0) begin n_fail++; $display("FAIL reset_bz got=%h exp=0", bus.bk_bz); end
    n_checks++; if (bus.bk_ocid !== 12'h0) begin n_fail++; $display("FAIL reset_ocid got=%h exp=0", bus.bk_ocid); end
    n_checks++; if (bus.bk_data !== 128'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", bus.bk_data); end
    // Register contents are cleared by reset.
    set_wb(5'd30, 32'hAAAA5555);
    tick();
    clear_inputs();
    do_reset();
    set_req(6, 5'd30);
    tick();
    clear_inputs();
    tick();
    n_checks++; if (bus.bk_vld !== 4'b1000) begin n_fail++; $display("FAIL reset_regclr_vld got=%b exp=1000", bus.bk_vld); end
    n_checks++; if (bdata(3) !== 32'h0) begin n_fail++; $display("FAIL reset_regclr_data got=%h exp=0", bdata(3)); end
  endtask

  task automatic test_single_read();
    do_reset();
    $display("test_single_read");
    set_wb(5'd9, 32'hDEADBEEF);
    tick();
    clear_inputs();
    set_req(2, 5'd9);
    tick();
    clear_inputs();
    n_checks++; if (bus.req_rdy[2] !== 1'b0) begin n_fail++; $display("FAIL single_rdy_pending got=%b exp=0", bus.req_rdy[2]); end
    tick();
    n_checks++; if (bus.bk_vld !== 4'b0010) begin n_fail++; $display("FAIL single_vld got=%b exp=0010", bus.bk_vld); end
    n_checks++; if (ocid(1) !== 3'd2) begin n_fail++; $display("FAIL single_ocid got=%0d exp=2", ocid(1)); end
    n_checks++; if (bdata(1) !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data got=%h exp=deadbeef", bdata(1)); end
    n_checks++; if (bus.req_rdy[2] !== 1'b1) begin n_fail++; $display("FAIL single_rdy_back got=%b exp=1", bus.req_rdy[2]); end
    tick();
    n_checks++; if (bus.bk_vld !== 4'b0000) begin n_fail++; $display("FAIL single_vld_drop got=%b exp=0000", bus.bk_vld); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_seq [4];
    exp_seq[0] = 3'd0; exp_seq[1] = 3'd3; exp_seq[2] = 3'd5; exp_seq[3] = 3'd0;
    do_reset();
    $display("test_round_robin");
    set_req(0, 5'd1);
    set_req(3, 5'd2);
    set_req(5, 5'd3);
    tick();
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      // Refill slot 0 while slot 5 is being granted; pointer then wraps 6,7,0.
      if (k == 2) set_req(0, 5'd4);
      tick();
      clear_inputs();
      n_checks++; if (bus.bk_vld[0] !== 1'b1) begin n_fail++; $display("FAIL rr_vld[%0d] got=%b exp=1", k, bus.bk_vld[0]); end
      n_checks++; if (ocid(0) !== exp_seq[k]) begin n_fail++; $display("FAIL rr_ocid[%0d] got=%0d exp=%0d", k, ocid(0), exp_seq[k]); end
    end
    tick();
    n_checks++; if (bus.bk_vld[0] !== 1'b0) begin n_fail++; $display("FAIL rr_idle got=%b exp=0", bus.bk_vld[0]); end
    // Winner 7 must wrap the pointer to 0: slot 0 then beats slot 7.
    do_reset();
    set_req(7, 5'd6);
    tick();
    clear_inputs();
    tick();
    n_checks++; if (ocid(0) !== 3'd7 || bus.bk_vld[0] !== 1'b1) begin n_fail++; $display("FAIL rr_wrap7 got=%0d/%b exp=7/1", ocid(0), bus.bk_vld[0]); end
    set_req(7, 5'd6);
    set_req(0, 5'd7);
    tick();
    clear_inputs();
    tick();
    n_checks++; if (ocid(0) !== 3'd0) begin n_fail++; $display("FAIL rr_wrap_first got=%0d exp=0", ocid(0)); end
    tick();
    n_checks++; if (ocid(0) !== 3'd7 || bus.bk_vld[0] !== 1'b1) begin n_fail++; $display("FAIL rr_wrap_second got=%0d/%b exp=7/1", ocid(0), bus.bk_vld[0]); end
  endtask

  task automatic test_parallel_banks();
    do_reset();
    $display("test_parallel_banks");
    set_wb(5'd24, 32'hCAFE0024);
    tick();
    clear_inputs();
    set_req(0, 5'd0);
    set_req(1, 5'd8);
    set_req(2, 5'd16);
    set_req(3, 5'd24);
    tick();
    clear_inputs();
    tick();
    n_checks++; if (bus.bk_vld !== 4'hF) begin n_fail++; $display("FAIL par_vld got=%b exp=1111", bus.bk_vld); end
    n_checks++; if (bus.bk_ocid !== {3'd3, 3'd2, 3'd1, 3'd0}) begin n_fail++; $display("FAIL par_ocid got=%h exp=%h", bus.bk_ocid, {3'd3, 3'd2, 3'd1, 3'd0}); end
    n_checks++; if (bdata(3) !== 32'hCAFE0024) begin n_fail++; $display("FAIL par_data3 got=%h exp=cafe0024", bdata(3)); end
  endtask

  task automatic test_writeback_block();
    do_reset();
    $display("test_writeback_block");
    set_req(4, 5'd17);
    tick();
    clear_inputs();
    set_wb(5'd20, 32'h00000077);
    tick();
    clear_inputs();
    n_checks++; if (bus.bk_bz[2] !== 1'b1 || bus.bk_vld[2] !== 1'b0) begin n_fail++; $display("FAIL wb_block got=bz%b vld%b exp=bz1 vld0", bus.bk_bz[2], bus.bk_vld[2]); end
    n_checks++; if (bus.req_rdy[4] !== 1'b0) begin n_fail++; $display("FAIL wb_still_pending got=%b exp=0", bus.req_rdy[4]); end
    tick();
    n_checks++; if (bus.bk_vld[2] !== 1'b1 || ocid(2) !== 3'd4 || bus.bk_bz[2] !== 1'b0) begin n_fail++; $display("FAIL wb_after got=vld%b ocid%0d bz%b exp=vld1 ocid4 bz0", bus.bk_vld[2], ocid(2), bus.bk_bz[2]); end
    n_checks++; if (bdata(2) !== 32'h0) begin n_fail++; $display("FAIL wb_after_data got=%h exp=0", bdata(2)); end
    // Same register pending while it is written.
    set_req(4, 5'd17);
    tick();
    clear_inputs();
    set_wb(5'd17, 32'h00000055);
    tick();
    clear_inputs();
`ifdef OC_WB_FORWARD_EN
    n_checks++; if (bus.bk_vld[2] !== 1'b1 || bus.bk_bz[2] !== 1'b0 || bdata(2) !== 32'h55) begin n_fail++; $display("FAIL wb_fwd got=vld%b bz%b data%h exp=vld1 bz0 data55", bus.bk_vld[2], bus.bk_bz[2], bdata(2)); end
`else
    n_checks++; if (bus.bk_vld[2] !== 1'b0 || bus.bk_bz[2] !== 1'b1) begin n_fail++; $display("FAIL wb_same_block got=vld%b bz%b exp=vld0 bz1", bus.bk_vld[2], bus.bk_bz[2]); end
    tick();
    n_checks++; if (bus.bk_vld[2] !== 1'b1 || bdata(2) !== 32'h55) begin n_fail++; $display("FAIL wb_raw got=vld%b data%h exp=vld1 data55", bus.bk_vld[2], bdata(2)); end
`endif
  endtask

  task automatic test_duplicate();
    int grants;
    logic bz_seen;
    grants  = 0;
    bz_seen = 1'b0;
    do_reset();
    $display("test_duplicate");
    set_req(1, 5'd2);
    set_wb(5'd5, 32'h12345678);
    for (int c = 0; c < 8; c++) begin
      if (c == 3) clear_inputs();
      tick();
      if (bus.bk_vld[0] === 1'b1) begin
        grants++;
        n_checks++; if (ocid(0) !== 3'd1 || c != 3) begin n_fail++; $display("FAIL dup_grant got=slot%0d cyc%0d exp=slot1 cyc3", ocid(0), c); end
      end
      if (c == 1) bz_seen = bus.bk_bz[0];
    end
    n_checks++; if (bz_seen !== 1'b1) begin n_fail++; $display("FAIL dup_bz got=%b exp=1", bz_seen); end
    n_checks++; if (grants != 1) begin n_fail++; $display("FAIL dup_count got=%0d exp=1", grants); end
    n_checks++; if (bus.req_rdy !== 8'hFF) begin n_fail++; $display("FAIL dup_rdy got=%h exp=ff", bus.req_rdy); end
  endtask

  task automatic test_reset_midflight();
    int vld_seen;
    vld_seen = 0;
    do_reset();
    $display("test_reset_midflight");
    set_req(0, 5'd24);
    set_req(4, 5'd25);
    set_req(6, 5'd26);
    tick();
    clear_inputs();
    n_checks++; if (bus.req_rdy !== 8'hAE) begin n_fail++; $display("FAIL mid_pending got=%h exp=ae", bus.req_rdy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (bus.req_rdy !== 8'hFF || bus.bk_bz !== 4'h0) begin n_fail++; $display("FAIL mid_state got=rdy%h bz%h exp=rdyff bz0", bus.req_rdy, bus.bk_bz); end
    for (int c = 0; c < 5; c++) begin
      if (bus.bk_vld !== 4'h0) vld_seen++;
      tick();
    end
    n_checks++; if (vld_seen != 0) begin n_fail++; $display("FAIL mid_novld got=%0d exp=0", vld_seen); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_parallel_banks();
    test_writeback_block();
    test_duplicate();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
